// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared types and constants for the multi-cycle sequencer       |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 12;

   localparam logic [OPC_HI-OPC_LO:0] HALT_OPCODE_DEFAULT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/retire_counter.sv
// +--------------------------------------------------------------------------+
// | retire_counter : wrapping counter with sync active-low clear and enable  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module retire_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// +--------------------------------------------------------------------------+
// | cpu_sequencer : multi-cycle fetch/decode/exec/mem/wb control sequencer.  |
// | Optional CPU_SINGLE_STEP_EN adds a `step` input gating IDLE -> FETCH.    |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int                      PC_W        = 8,
   parameter logic [PC_W-1:0]         RESET_PC    = '0,
   parameter logic [OPC_HI-OPC_LO:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
   parameter int                      CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef CPU_SINGLE_STEP_EN
   input  logic               step,
`endif
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction,
   input  logic               dec_reg_write,
   input  logic               dec_mem_write,
   input  logic               dec_mem_to_reg,
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ack,
   output logic               rf_we,
   output logic [PC_W-1:0]    pc,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

`ifdef CPU_SINGLE_STEP_EN
   localparam state_t RETIRE_NXT = S_IDLE;
`else
   localparam state_t RETIRE_NXT = S_FETCH;
`endif

   state_t state;
   state_t state_nxt;
   logic   retire;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         instruction <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && imem_ack) begin
            instruction <= imem_rdata;
            pc          <= pc + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         S_IDLE: begin
`ifdef CPU_SINGLE_STEP_EN
            if (step) state_nxt = S_FETCH;
`else
            state_nxt = S_FETCH;
`endif
         end
         S_FETCH: begin
            if (imem_ack) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (instruction[OPC_HI:OPC_LO] == HALT_OPCODE) state_nxt = S_HALT;
            else                                            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (dec_mem_write || dec_mem_to_reg) begin
               state_nxt = S_MEM;
            end else if (dec_reg_write) begin
               state_nxt = S_WB;
            end else begin
               state_nxt = RETIRE_NXT;
               retire    = 1'b1;
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (dec_mem_to_reg) begin
                  state_nxt = S_WB;
               end else begin
                  state_nxt = RETIRE_NXT;
                  retire    = 1'b1;
               end
            end
         end
         S_WB: begin
            state_nxt = RETIRE_NXT;
            retire    = 1'b1;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Strobes are pure decodes of the registered state.
   assign imem_req  = (state == S_FETCH);
   assign imem_addr = pc;
   assign dmem_req  = (state == S_MEM);
   assign dmem_we   = (state == S_MEM) && dec_mem_write;
   assign rf_we     = (state == S_WB);
   assign halted    = (state == S_HALT);

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (retire),
      .count (retired)
   );

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_cpu_sequencer : random program against a scoreboard of expected events |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_sequencer;

   localparam int N_INSTR = 300;
`ifdef CPU_SINGLE_STEP_EN
   localparam int STEP_EXTRA = 1;
`else
   localparam int STEP_EXTRA = 0;
`endif
   localparam int K_FETCH = 0;
   localparam int K_DMEM  = 1;
   localparam int K_RF    = 2;
   localparam int K_HALT  = 3;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] ret;
      logic [31:0] we;
      int          gap;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        step;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, halted;
   logic [7:0]  imem_addr, pc;
   logic [15:0] imem_rdata, instruction, retired;
   logic        dec_reg_write, dec_mem_write, dec_mem_to_reg;

   logic [15:0] prog [N_INSTR];
   int          fidx = 0;
   int          iw = 0;
   int          dw = 0;
   logic        spur_i = 1'b0;
   logic        spur_d = 1'b0;

   ev_t         exp_q[$];
   ev_t         e;
   int          kind;
   int          since = 0;
   int          waits = 0;
   bit          mon_en = 1'b0;
   bit          seen_halt = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   cpu_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
`ifdef CPU_SINGLE_STEP_EN
      .step           (step),
`endif
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instruction    (instruction),
      .dec_reg_write  (dec_reg_write),
      .dec_mem_write  (dec_mem_write),
      .dec_mem_to_reg (dec_mem_to_reg),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_ack       (dmem_ack),
      .rf_we          (rf_we),
      .pc             (pc),
      .halted         (halted),
      .retired        (retired)
   );

   // Opcodes: 1 ALU+writeback, 2 store, 3 load, F halt, anything else no-write.
   always_comb begin
      dec_reg_write  = (instruction[15:12] == 4'h1) || (instruction[15:12] == 4'h3);
      dec_mem_write  = (instruction[15:12] == 4'h2);
      dec_mem_to_reg = (instruction[15:12] == 4'h3);
   end

   // Memory models: combinational ack after a random number of wait cycles,
   // plus random acks while no request is outstanding.
   always_comb begin
      imem_ack   = imem_req ? (iw == 0) : spur_i;
      dmem_ack   = dmem_req ? (dw == 0) : spur_d;
      imem_rdata = (fidx < N_INSTR) ? prog[fidx] : 16'h0000;
   end

   always @(posedge clk) begin
      if (rst_n === 1'b1 && imem_req === 1'b1) begin
         if (iw == 0) begin
            fidx <= fidx + 1;
            iw   <= ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         end else begin
            iw <= iw - 1;
         end
      end
      if (rst_n === 1'b1 && dmem_req === 1'b1) begin
         if (dw == 0) dw <= ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         else         dw <= dw - 1;
      end
   end

   always @(negedge clk) begin
      spur_i = ($urandom_range(0, 3) == 0);
      spur_d = ($urandom_range(0, 3) == 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Monitor: classify each handshake/strobe and compare against the queue.
   // The gap is measured from the previous event, not counting wait cycles.
   always @(negedge clk) begin
      if (mon_en) begin
         since++;
         kind = -1;
         if (imem_req && imem_ack)      kind = K_FETCH;
         else if (dmem_req && dmem_ack) kind = K_DMEM;
         else if (rf_we)                kind = K_RF;
         else if (halted && !seen_halt) begin
            kind      = K_HALT;
            seen_halt = 1'b1;
         end
         if (kind >= 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", kind, 32'hFF);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", kind, e.kind);
               chk("instruction", {16'h0, instruction}, e.instr);
               chk("retired", {16'h0, retired}, e.ret);
               if (kind == K_FETCH) begin
                  chk("imem_addr", {24'h0, imem_addr}, e.addr);
                  chk("pc", {24'h0, pc}, e.addr);
               end
               if (kind == K_DMEM) chk("dmem_we", {31'h0, dmem_we}, e.we);
               if (e.gap >= 0) chk("event_gap", since - waits, e.gap);
            end
            since = 0;
            waits = 0;
         end else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
            waits++;
         end
      end
   end

   task automatic push(input int k, input int a, input logic [15:0] ir,
                       input int r, input logic w, input int g);
      ev_t x;
      x.kind  = k;
      x.addr  = a;
      x.instr = {16'h0, ir};
      x.ret   = r;
      x.we    = {31'h0, w};
      x.gap   = g;
      exp_q.push_back(x);
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] prev_ir;
      int          next_gap;
      int          bad;

      step  = 1'b1;
      rst_n = 1'b0;

      for (int i = 0; i < N_INSTR - 1; i++) begin
         op      = 4'($urandom_range(0, 14));
         prog[i] = {op, 12'($urandom)};
      end
      prog[N_INSTR-1] = {4'hF, 12'($urandom)};

      // Reference: event sequence and cycle gaps of each instruction class.
      prev_ir  = 16'h0;
      next_gap = -1;
      for (int i = 0; i < N_INSTR; i++) begin
         op = prog[i][15:12];
         push(K_FETCH, i % 256, prev_ir, i, 1'b0, next_gap);
         if (op == 4'hF) begin
            push(K_HALT, 0, prog[i], i, 1'b0, 2);
            break;
         end else if (op == 4'h2) begin
            push(K_DMEM, 0, prog[i], i, 1'b1, 3);
            next_gap = 1 + STEP_EXTRA;
         end else if (op == 4'h3) begin
            push(K_DMEM, 0, prog[i], i, 1'b0, 3);
            push(K_RF, 0, prog[i], i, 1'b0, 1);
            next_gap = 1 + STEP_EXTRA;
         end else if (op == 4'h1) begin
            push(K_RF, 0, prog[i], i, 1'b0, 3);
            next_gap = 1 + STEP_EXTRA;
         end else begin
            next_gap = 3 + STEP_EXTRA;
         end
         prev_ir = prog[i];
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_imem_req", {31'h0, imem_req}, 0);
      chk("reset_dmem_req", {31'h0, dmem_req}, 0);
      chk("reset_rf_we", {31'h0, rf_we}, 0);
      chk("reset_halted", {31'h0, halted}, 0);
      chk("reset_pc", {24'h0, pc}, 0);
      chk("reset_instruction", {16'h0, instruction}, 0);
      chk("reset_retired", {16'h0, retired}, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("first_imem_req", {31'h0, imem_req}, 1);

      for (int c = 0; c < 30000 && !seen_halt; c++) @(negedge clk);
      chk("halt_reached", {31'h0, seen_halt}, 1);

      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req !== 1'b0) bad++;
      end
      chk("no_fetch_after_halt", bad, 0);
      chk("halted_held", {31'h0, halted}, 1);
      chk("retired_final", {16'h0, retired}, N_INSTR - 1);
      chk("scoreboard_drained", exp_q.size(), 0);
      mon_en = 1'b0;

      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("halt_reset_halted", {31'h0, halted}, 0);
      chk("halt_reset_pc", {24'h0, pc}, 0);
      chk("halt_reset_retired", {16'h0, retired}, 0);
      chk("halt_reset_instruction", {16'h0, instruction}, 0);

      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midop_reset_imem_req", {31'h0, imem_req}, 0);
      chk("midop_reset_dmem_req", {31'h0, dmem_req}, 0);
      chk("midop_reset_rf_we", {31'h0, rf_we}, 0);
      chk("midop_reset_pc", {24'h0, pc}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
